data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Arbitrates the single-port DataMemory between two requesters: port 0 (decode-stage memory-operand reads) and port 1 (writeback-stage stores/loads). Each request is latched, the memory strobes are sequenced with a small FSM, and a one-cycle completion pulse is returned to the requester with read data where applicable. The block sits between the pipeline stages and DataMemory and is the only driver of the memory's `rd_mem`/`wr_mem`/`address`/`mode_mem`/`write_data_mem` inputs.

## Interface
- `DATA_W`, 16, data width of memory words
- `ADDR_W`, 16, memory address width

- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req0` / `req1`  in  1  request from port 0 / port 1; held high until `done` is seen
- `wr0` / `wr1`  in  1  1 = write, 0 = read; stable while `req` is high
- `addr0` / `addr1`  in  ADDR_W  access address
- `mode0` / `mode1`  in  1  access mode, passed to `mode_mem` unchanged
- `wdata0` / `wdata1`  in  DATA_W  write data
- `done0` / `done1`  out  1  one-cycle completion pulse
- `rdata0` / `rdata1`  out  DATA_W  read data, valid while matching `done` is high
- `rd_mem`  out  1  memory read strobe
- `wr_mem`  out  1  memory write strobe
- `address`  out  ADDR_W  memory address
- `mode_mem`  out  1  memory access mode
- `write_data_mem`  out  DATA_W  memory write data
- `mem_data`  in  DATA_W  memory read data, valid the cycle after `rd_mem`
- `busy`  out  1  high in any state except IDLE
- `owner`  out  1  port index of the transaction in flight (last winner when IDLE)

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE: if any `req` is high, select winner, latch its `wr`/`addr`/`mode`/`wdata` into internal registers, set `owner`, go ISSUE; otherwise stay.
- ISSUE: drive `address`, `mode_mem`, `write_data_mem` from latched fields; `rd_mem` = !wr, `wr_mem` = wr. Next: CAPTURE if read, DONE if write.
- CAPTURE: strobes low; register `mem_data` into the read-data register at the end of the cycle. Next: DONE.
- DONE: assert `done[owner]`. `rdata[owner]` = captured data (reads), 0 for writes. Next: IDLE.
- Request fields are sampled only at the IDLE->ISSUE edge; later changes are ignored.
- A `req` still high in IDLE is a new request; requesters must drop `req` on the edge where they sample `done`.
- Non-owner `done` and `rdata` are 0. `address`/`mode_mem`/`write_data_mem` hold latched values outside ISSUE; only the strobes are qualified.
- Arbitration on simultaneous requests: see Configuration. A single requester always wins.

## Timing
- Reset values: state IDLE, `rd_mem`=`wr_mem`=0, `address`=0, `mode_mem`=0, `write_data_mem`=0, `done0`=`done1`=0, `rdata0`=`rdata1`=0, `busy`=0, `owner`=1 (last-winner register = 1).
- Request sampled high at end of cycle 0: read -> ISSUE cycle 1, CAPTURE cycle 2, `done` cycle 3; write -> ISSUE cycle 1, `done` cycle 2.
- Minimum spacing of back-to-back transactions: 4 cycles (read), 3 cycles (write), including one IDLE cycle.
- Reset asserted in any state: next cycle is IDLE with all outputs at reset values; in-flight transaction is dropped, no `done` is issued; an issued write may already have taken effect.
- No combinational path from any `req` or `mem_data` to any output.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On simultaneous requests in IDLE, the port that is not the last winner wins. After reset, port 0 wins first.
- Not defined: fixed priority, port 1 always wins ties (older instruction first); port 0 can starve under continuous port 1 traffic.

## Test plan
- Single read: memory[0x0004]=0x1234, `req0`=1,`wr0`=0,`addr0`=0x0004 -> `rd_mem`=1 with `address`=0x0004 in cycle 1 only; `done0`=1 with `rdata0`=0x1234 in cycle 3; `done1`=0 throughout.
- Write then read: port 1 writes 0xBEEF to 0x0006 -> `wr_mem`=1 with `write_data_mem`=0xBEEF in cycle 1, `done1` in cycle 2; a following port 0 read of 0x0006 returns 0xBEEF.
- Tie after reset, both reads: without macro -> port 1 served first (`done1` cycle 3), then port 0 (`done0` cycle 7). With `MEM_ARB_RR_EN` -> port 0 first, then port 1.
- Continuous requests on both ports for 24 cycles: with macro -> grants alternate 0,1,0,1,...; without macro -> port 1 completes every transaction and `done0` never asserts.
- Reset asserted during CAPTURE -> next cycle `busy`=0, strobes 0, no `done` pulse; a request held high afterward is serviced normally from IDLE.
- Change `addr0` from 0x0004 to 0x0008 during ISSUE -> the access still uses 0x0004.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single-port DataMemory between two requesters. Port 0 is the
//   decode-stage operand read. Port 1 is the writeback-stage store/load. The
//   winning request is latched in IDLE. A four-state FSM then sequences the
//   memory strobes and returns a one-cycle done pulse to the owner. For reads
//   the pulse carries the captured read data.
//
//   Build option: MEM_ARB_RR_EN
//     defined   -> round-robin. On a tie the port that did not win last time
//                  wins. After reset port 0 wins first.
//     undefined -> fixed priority. Port 1 wins every tie.
//
//   Handshake: a requester raises reqN with wrN/addrN/modeN/wdataN stable. It
//   holds reqN until it samples doneN high, and drops reqN on that same edge.
//   A reqN still high when the FSM is back in IDLE counts as a new request.
//
//   Ports
//     clk, reset            clock and synchronous active-high reset
//     req0/1, wr0/1         request and direction (1 = write)
//     addr0/1, mode0/1      access address and mode
//     wdata0/1              write data
//     done0/1, rdata0/1     completion pulse and read data (0 for writes)
//     rd_mem, wr_mem        memory strobes, high only in ISSUE
//     address, mode_mem,    latched access fields; they hold their values
//     write_data_mem          outside ISSUE
//     mem_data              memory read data, valid the cycle after rd_mem
//     busy                  high in any state except IDLE
//     owner                 port of the transaction in flight (last winner)
//     dbg_state             current FSM state (IDLE=0 ISSUE=1 CAPTURE=2 DONE=3)
module data_mem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              mode0,
  input  logic              mode1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [ADDR_W-1:0] address,
  output logic              mode_mem,
  output logic [DATA_W-1:0] write_data_mem,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_mode;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_owner;
  logic                r_rd_mem;
  logic                r_wr_mem;
  logic                r_done0;
  logic                r_done1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_busy;

  logic                w_win;
  logic                w_sel_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_sel_mode;
  logic [DATA_W-1:0]   w_sel_wdata;

  // Winner selection. This logic only feeds registers, so there is no
  // combinational path from any req to any output.
  always_comb begin
    w_win = req1;
`ifdef MEM_ARB_RR_EN
    if (req0 && req1) begin
      w_win = ~r_owner;
    end
`endif
    w_sel_wr    = w_win ? wr1    : wr0;
    w_sel_addr  = w_win ? addr1  : addr0;
    w_sel_mode  = w_win ? mode1  : mode0;
    w_sel_wdata = w_win ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_mode   <= 1'b0;
      r_wdata  <= '0;
      r_owner  <= 1'b1;
      r_rd_mem <= 1'b0;
      r_wr_mem <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_busy   <= 1'b0;
    end else begin
      // Strobes and completion outputs are pulses. Each is raised only on
      // the transition into the state that owns it.
      r_rd_mem <= 1'b0;
      r_wr_mem <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      case (r_state)
        IDLE: begin
          if (req0 || req1) begin
            r_wr     <= w_sel_wr;
            r_addr   <= w_sel_addr;
            r_mode   <= w_sel_mode;
            r_wdata  <= w_sel_wdata;
            r_owner  <= w_win;
            r_rd_mem <= ~w_sel_wr;
            r_wr_mem <= w_sel_wr;
            r_busy   <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_wr) begin
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            r_state <= DONE;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // mem_data is valid in this cycle because rd_mem was high last cycle.
          r_done0 <= ~r_owner;
          r_done1 <= r_owner;
          if (r_owner) begin
            r_rdata1 <= mem_data;
          end else begin
            r_rdata0 <= mem_data;
          end
          r_state <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign done0          = r_done0;
  assign done1          = r_done1;
  assign rdata0         = r_rdata0;
  assign rdata1         = r_rdata1;
  assign rd_mem         = r_rd_mem;
  assign wr_mem         = r_wr_mem;
  assign address        = r_addr;
  assign mode_mem       = r_mode;
  assign write_data_mem = r_wdata;
  assign busy           = r_busy;
  assign owner          = r_owner;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, wr0, wr1, mode0, mode1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1;
  logic [15:0] rdata0, rdata1;
  logic        rd_mem, wr_mem, mode_mem;
  logic [15:0] address, write_data_mem;
  logic [15:0] mem_data;
  logic        busy, owner;
  logic [1:0]  dbg_state;

  logic [15:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  data_mem_arbiter #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .mode0(mode0), .mode1(mode1),
    .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .rd_mem(rd_mem), .wr_mem(wr_mem), .address(address),
    .mode_mem(mode_mem), .write_data_mem(write_data_mem),
    .mem_data(mem_data), .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory model: synchronous write, read data registered one cycle later
  always @(posedge clk) begin
    if (wr_mem) mem[address[7:0]] <= write_data_mem;
    if (rd_mem) mem_data <= mem[address[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; mode0 = 0; mode1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    cyc(); cyc();
  endtask

  int          d0_cyc, d1_cyc;
  logic [15:0] d0_val, d1_val;
  logic        got_q[$];
  logic        exp_q[$];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h04] = 16'h1234;
    mem[8'h08] = 16'h5555;
    mem[8'h10] = 16'hAAAA;
    mem[8'h20] = 16'hBBBB;
    mem_data = 16'h0;

    // reset values
    do_reset();
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b1);
    chk("rst_strobes", {rd_mem, wr_mem}, 2'b00);
    chk("rst_address", address, 16'h0);
    chk("rst_mode", mode_mem, 1'b0);
    chk("rst_wdata", write_data_mem, 16'h0);
    chk("rst_done", {done0, done1}, 2'b00);
    chk("rst_rdata", {rdata0, rdata1}, 32'h0);

    // single read, port 0, addr 4 (cycle 0 = this negedge)
    reset = 1'b0;
    req0 = 1; wr0 = 0; addr0 = 16'h0004; mode0 = 1;
    cyc(); // cycle 1
    chk("rd_issue_state", dbg_state, 2'd1);
    chk("rd_issue_strobes", {rd_mem, wr_mem}, 2'b10);
    chk("rd_issue_addr", address, 16'h0004);
    chk("rd_issue_mode", mode_mem, 1'b1);
    chk("rd_issue_owner", owner, 1'b0);
    chk("rd_issue_busy", busy, 1'b1);
    cyc(); // cycle 2
    chk("rd_cap_state", dbg_state, 2'd2);
    chk("rd_cap_strobes", {rd_mem, wr_mem}, 2'b00);
    chk("rd_cap_done", {done0, done1}, 2'b00);
    cyc(); // cycle 3
    chk("rd_done", {done0, done1}, 2'b10);
    chk("rd_rdata0", rdata0, 16'h1234);
    chk("rd_rdata1", rdata1, 16'h0);
    req0 = 0;
    cyc(); // cycle 4
    chk("rd_idle_busy", busy, 1'b0);
    chk("rd_idle_done", {done0, done1}, 2'b00);

    // port 1 write 0xBEEF to 6, then port 0 reads it back
    req1 = 1; wr1 = 1; addr1 = 16'h0006; wdata1 = 16'hBEEF; mode1 = 1;
    cyc(); // cycle 1
    chk("wr_issue_strobes", {rd_mem, wr_mem}, 2'b01);
    chk("wr_issue_wdata", write_data_mem, 16'hBEEF);
    chk("wr_issue_addr", address, 16'h0006);
    chk("wr_issue_owner", owner, 1'b1);
    cyc(); // cycle 2
    chk("wr_done", {done0, done1}, 2'b01);
    chk("wr_rdata1", rdata1, 16'h0);
    chk("wr_hold_addr", address, 16'h0006);
    chk("wr_done_strobes", {rd_mem, wr_mem}, 2'b00);
    req1 = 0;
    cyc(); // idle
    chk("wr_idle_state", dbg_state, 2'd0);
    req0 = 1; wr0 = 0; addr0 = 16'h0006;
    cyc(); cyc(); cyc();
    chk("rb_done", {done0, done1}, 2'b10);
    chk("rb_rdata0", rdata0, 16'hBEEF);
    req0 = 0;
    cyc();

    // tie after reset, both reads
    do_reset();
    reset = 1'b0;
    req0 = 1; wr0 = 0; addr0 = 16'h0010;
    req1 = 1; wr1 = 0; addr1 = 16'h0020;
    d0_cyc = -1; d1_cyc = -1; d0_val = 0; d1_val = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      if (done0) begin d0_cyc = c; d0_val = rdata0; req0 = 0; end
      if (done1) begin d1_cyc = c; d1_val = rdata1; req1 = 0; end
    end
`ifdef MEM_ARB_RR_EN
    chk("tie_done0_cycle", d0_cyc, 3);
    chk("tie_done1_cycle", d1_cyc, 7);
`else
    chk("tie_done1_cycle", d1_cyc, 3);
    chk("tie_done0_cycle", d0_cyc, 7);
`endif
    chk("tie_rdata0", d0_val, 16'hAAAA);
    chk("tie_rdata1", d1_val, 16'hBBBB);

    // continuous requests on both ports for 24 cycles
    do_reset();
    reset = 1'b0;
    wr0 = 0; addr0 = 16'h0010; wr1 = 0; addr1 = 16'h0020;
    for (int c = 0; c < 24; c++) begin
      if (done0) begin
        got_q.push_back(1'b0);
        chk("cont_rdata0", rdata0, 16'hAAAA);
      end
      if (done1) begin
        got_q.push_back(1'b1);
        chk("cont_rdata1", rdata1, 16'hBBBB);
      end
      req0 = ~done0;
      req1 = ~done1;
      cyc();
    end
    for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_q.push_back(k[0]);
`else
      exp_q.push_back(1'b1);
`endif
    end
    chk("cont_count", got_q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < got_q.size()) chk($sformatf("cont_grant%0d", k), got_q[k], exp_q[k]);
    end
    req0 = 0; req1 = 0;
    cyc(); cyc(); cyc(); cyc();

    // reset during CAPTURE, request held afterward
    req0 = 1; wr0 = 0; addr0 = 16'h0004;
    cyc(); cyc(); // cycle 2: CAPTURE
    chk("rc_pre_state", dbg_state, 2'd2);
    reset = 1'b1;
    cyc();
    chk("rc_busy", busy, 1'b0);
    chk("rc_strobes", {rd_mem, wr_mem}, 2'b00);
    chk("rc_done", {done0, done1}, 2'b00);
    chk("rc_owner", owner, 1'b1);
    chk("rc_address", address, 16'h0);
    reset = 1'b0;
    cyc();
    chk("rc_issue_strobes", {rd_mem, wr_mem}, 2'b10);
    cyc();
    chk("rc_cap_done", {done0, done1}, 2'b00);
    cyc();
    chk("rc_done2", {done0, done1}, 2'b10);
    chk("rc_rdata0", rdata0, 16'h1234);
    req0 = 0;
    cyc();

    // address change during ISSUE is ignored
    req0 = 1; wr0 = 0; addr0 = 16'h0004;
    cyc(); // ISSUE
    addr0 = 16'h0008;
    chk("ac_issue_addr", address, 16'h0004);
    cyc();
    chk("ac_cap_addr", address, 16'h0004);
    cyc();
    chk("ac_done", {done0, done1}, 2'b10);
    chk("ac_rdata0", rdata0, 16'h1234);
    req0 = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
